// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths, zero-register index and MIPS register names for the register file.
package reg_file_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_ZERO   = 0;
   localparam int T0 = 8,  T1 = 9,  T2 = 10, T3 = 11, T4 = 12, T5 = 13, T6 = 14, T7 = 15;
   localparam int S0 = 16, S1 = 17, S2 = 18, S3 = 19, S4 = 20, S5 = 21, S6 = 22, S7 = 23;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write flags set at issue, cleared at writeback or flush.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_reg,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic              rd1_busy,
   output logic              rd2_busy,
   output logic              any_busy
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
   logic [DEPTH-1:0] busy_q, busy_d;
   logic issue_ok;
   assign issue_ok = issue_valid && !(ZERO_REG != 0 && issue_reg == ZERO_ADDR);
   // Later assignments win: issue overrides a same-cycle clear, flush overrides everything.
   always_comb begin
      busy_d = busy_q;
      if (reg_write) busy_d[write_reg] = 1'b0;
      if (issue_ok) busy_d[issue_reg] = 1'b1;
      if (flush) busy_d = '0;
   end
   always_ff @(posedge clock) begin
      if (reset) busy_q <= '0;
      else busy_q <= busy_d;
   end
   assign rd1_busy = busy_q[read_reg1] && !(BYPASS != 0 && reg_write && write_reg == read_reg1);
   assign rd2_busy = busy_q[read_reg2] && !(BYPASS != 0 && reg_write && write_reg == read_reg2);
   assign any_busy = |busy_q;
endmodule

// File: rtl/pipe_reg_file.sv
// pipe_reg_file: 2R1W register file with write-to-read bypass, optional zero register and busy scoreboard.
module pipe_reg_file
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_reg,
   input  logic              flush,
   output logic              rd1_busy,
   output logic              rd2_busy,
   output logic              any_busy
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic wr_ok, zero1, zero2, fwd1, fwd2;
   assign wr_ok = reg_write && !(ZERO_REG != 0 && write_reg == ZERO_ADDR);
   always_ff @(posedge clock) begin
      if (reset) regs_q <= '{default: '0};
      else if (wr_ok) regs_q[write_reg] <= write_data;
   end
   assign zero1 = ZERO_REG != 0 && read_reg1 == ZERO_ADDR;
   assign zero2 = ZERO_REG != 0 && read_reg2 == ZERO_ADDR;
   assign fwd1  = BYPASS != 0 && reg_write && write_reg == read_reg1;
   assign fwd2  = BYPASS != 0 && reg_write && write_reg == read_reg2;
   assign read_data1 = zero1 ? '0 : fwd1 ? write_data : regs_q[read_reg1];
   assign read_data2 = zero2 ? '0 : fwd2 ? write_data : regs_q[read_reg2];
   reg_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_sb (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .issue_valid(issue_valid),
      .issue_reg  (issue_reg),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .rd1_busy   (rd1_busy),
      .rd2_busy   (rd2_busy),
      .any_busy   (any_busy)
   );
endmodule

// File: tb/tb_pipe_reg_file.sv
// tb_pipe_reg_file: directed checks of data, bypass, zero register and scoreboard behaviour.
module tb_pipe_reg_file;
   logic        clock = 1'b0;
   logic        reset, reg_write, issue_valid, flush;
   logic [4:0]  write_reg, read_reg1, read_reg2, issue_reg;
   logic [31:0] write_data;
   logic [31:0] read_data1, read_data2, nz_data1, nz_data2;
   logic        rd1_busy, rd2_busy, any_busy, nz_busy1, nz_busy2, nz_any;
   int n_checks = 0;
   int n_fail = 0;
   always #5 clock = ~clock;
   pipe_reg_file dut (
      .clock(clock), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
      .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(read_data1), .read_data2(read_data2), .issue_valid(issue_valid),
      .issue_reg(issue_reg), .flush(flush), .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
      .any_busy(any_busy)
   );
   pipe_reg_file #(.ZERO_REG(0)) dut_nz (
      .clock(clock), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
      .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(nz_data1), .read_data2(nz_data2), .issue_valid(issue_valid),
      .issue_reg(issue_reg), .flush(flush), .rd1_busy(nz_busy1), .rd2_busy(nz_busy2),
      .any_busy(nz_any)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   initial begin
      reset = 1'b1; reg_write = 1'b0; issue_valid = 1'b0; flush = 1'b0;
      write_reg = '0; read_reg1 = '0; read_reg2 = '0; issue_reg = '0; write_data = '0;
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_rd1", read_data1, 32'h0);
      chk("rst_rd2", read_data2, 32'h0);
      chk("rst_busy1", 32'(rd1_busy), 32'h0);
      chk("rst_any", 32'(any_busy), 32'h0);
      // reset clears a written register
      reg_write = 1'b1; write_reg = 5'd16; write_data = 32'hDEAD_BEEF;
      step();
      reg_write = 1'b0; read_reg1 = 5'd16;
      #1 chk("wr16", read_data1, 32'hDEAD_BEEF);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1 chk("rst16", read_data1, 32'h0);
      chk("rst16_any", 32'(any_busy), 32'h0);
      // bypass
      reg_write = 1'b1; write_reg = 5'd17; write_data = 32'h1234; read_reg2 = 5'd17;
      #1 chk("byp_pre", read_data2, 32'h1234);
      step();
      reg_write = 1'b0;
      #1 chk("byp_post", read_data2, 32'h1234);
      // zero register
      reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
      issue_valid = 1'b1; issue_reg = 5'd0; read_reg1 = 5'd0;
      #1 chk("zero_byp", read_data1, 32'h0);
      chk("nz_byp", nz_data1, 32'hFFFF_FFFF);
      step();
      reg_write = 1'b0; issue_valid = 1'b0;
      #1 chk("zero_rd", read_data1, 32'h0);
      chk("zero_busy", 32'(rd1_busy), 32'h0);
      chk("nz_rd", nz_data1, 32'hFFFF_FFFF);
      chk("nz_busy", 32'(nz_busy1), 32'h1);
      // scoreboard set/clear
      issue_valid = 1'b1; issue_reg = 5'd18;
      step();
      issue_valid = 1'b0; read_reg1 = 5'd18;
      #1 chk("sb_set", 32'(rd1_busy), 32'h1);
      chk("sb_any", 32'(any_busy), 32'h1);
      reg_write = 1'b1; write_reg = 5'd18; write_data = 32'd5;
      #1 chk("sb_wr_busy", 32'(rd1_busy), 32'h0);
      chk("sb_wr_data", read_data1, 32'd5);
      step();
      reg_write = 1'b0;
      #1 chk("sb_clr", 32'(rd1_busy), 32'h0);
      chk("sb_data", read_data1, 32'd5);
      chk("sb_any_clr", 32'(any_busy), 32'h0);
      // issue and writeback to the same busy register
      issue_valid = 1'b1; issue_reg = 5'd19;
      step();
      reg_write = 1'b1; write_reg = 5'd19; write_data = 32'd7; read_reg1 = 5'd19;
      #1 chk("col_pre_busy", 32'(rd1_busy), 32'h0);
      step();
      reg_write = 1'b0; issue_valid = 1'b0;
      #1 chk("col_data", read_data1, 32'd7);
      chk("col_busy", 32'(rd1_busy), 32'h1);
      // flush with a same-cycle issue
      issue_valid = 1'b1; issue_reg = 5'd16;
      step();
      issue_reg = 5'd20;
      step();
      issue_reg = 5'd23;
      step();
      issue_valid = 1'b0; read_reg1 = 5'd20; read_reg2 = 5'd23;
      #1 chk("fl_pre1", 32'(rd1_busy), 32'h1);
      chk("fl_pre2", 32'(rd2_busy), 32'h1);
      flush = 1'b1; issue_valid = 1'b1; issue_reg = 5'd21;
      step();
      flush = 1'b0; issue_valid = 1'b0; read_reg1 = 5'd21; read_reg2 = 5'd19;
      #1 chk("fl_any", 32'(any_busy), 32'h0);
      chk("fl_nz_any", 32'(nz_any), 32'h0);
      chk("fl_busy21", 32'(rd1_busy), 32'h0);
      chk("fl_data19", read_data2, 32'd7);
      read_reg1 = 5'd18;
      #1 chk("fl_data18", read_data1, 32'd5);
      // reset wins over a same-cycle write
      reset = 1'b1; reg_write = 1'b1; write_reg = 5'd22; write_data = 32'hAAAA_5555;
      step();
      reset = 1'b0; reg_write = 1'b0; read_reg1 = 5'd22;
      #1 chk("rstwr_22", read_data1, 32'h0);
      chk("rstwr_19", read_data2, 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
